// File: rtl/serial_receive.sv
// 8N1 UART receiver: 2-flop synchronizer, midpoint sampling, one-cycle ready and
// framing-error pulses, and a break state so a held-low line reports one error.
module serial_receive #(
  parameter int unsigned BIT_CLKS  = 10416,
  parameter int unsigned HALF_CLKS = 5208
) (
  input  logic       CLK_100_I,
  input  logic       RSTN_I,
  input  logic       SERIAL_I,
  output logic [7:0] BYTE_O,
  output logic       RDY_O,
  output logic       FRAME_ERR_O,
  output logic       BUSY_O
);

  localparam logic [13:0] BitLast  = 14'(BIT_CLKS - 1);
  localparam logic [13:0] HalfLast = 14'(HALF_CLKS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        rdy_q, rdy_d;
  logic        ferr_q, ferr_d;
  logic        sync_q, rx_q;

  always_ff @(posedge CLK_100_I) begin
    if (!RSTN_I) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      sync_q  <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      sync_q  <= SERIAL_I;
      rx_q    <= sync_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is gone by its midpoint was a glitch.
          state_d = rx_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_q) begin
            byte_d  = shift_q;
            rdy_d   = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      StBreak: begin
        if (rx_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign BYTE_O      = byte_q;
  assign RDY_O       = rdy_q;
  assign FRAME_ERR_O = ferr_q;
  assign BUSY_O      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_receive.sv
// Scoreboard bench for serial_receive at a scaled bit time of 100 clocks; expected
// ready/error events are queued by the stimulus and consumed by a pulse monitor.
module tb_serial_receive;

  localparam int unsigned Bit  = 100;
  localparam int unsigned Half = 50;

  logic       CLK_100_I = 1'b0;
  logic       RSTN_I    = 1'b0;
  logic       SERIAL_I  = 1'b1;
  logic [7:0] BYTE_O;
  logic       RDY_O, FRAME_ERR_O, BUSY_O;

  serial_receive #(.BIT_CLKS(Bit), .HALF_CLKS(Half)) dut (
    .CLK_100_I  (CLK_100_I),
    .RSTN_I     (RSTN_I),
    .SERIAL_I   (SERIAL_I),
    .BYTE_O     (BYTE_O),
    .RDY_O      (RDY_O),
    .FRAME_ERR_O(FRAME_ERR_O),
    .BUSY_O     (BUSY_O)
  );

  always #5 CLK_100_I = ~CLK_100_I;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_rdy = 1'b0, prev_ferr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge CLK_100_I) begin
    if (RDY_O && FRAME_ERR_O) check("rdy_and_ferr_together", 32'd1, 32'd0);
    if ((RDY_O && prev_rdy) || (FRAME_ERR_O && prev_ferr))
      check("pulse_two_cycles", 32'd1, 32'd0);
    if (RDY_O || FRAME_ERR_O) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {23'd0, FRAME_ERR_O, BYTE_O}, 32'hdead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, FRAME_ERR_O}, {31'd0, e.err});
        check("pulse_byte", {24'd0, BYTE_O}, {24'd0, e.data});
      end
    end
    prev_rdy  = RDY_O;
    prev_ferr = FRAME_ERR_O;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_100_I);
  endtask

  task automatic send_byte(input logic [7:0] b, input int period, input logic stop);
    SERIAL_I = 1'b0;
    idle(period);
    for (int i = 0; i < 8; i++) begin
      SERIAL_I = b[i];
      idle(period);
    end
    SERIAL_I = stop;
    idle(period);
    SERIAL_I = 1'b1;
  endtask

  task automatic expect_evt(input logic err, input logic [7:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    RSTN_I = 1'b0;
    idle(3);
    check("reset_byte", {24'd0, BYTE_O}, 32'h00);
    check("reset_rdy", {31'd0, RDY_O}, 32'd0);
    check("reset_ferr", {31'd0, FRAME_ERR_O}, 32'd0);
    check("reset_busy", {31'd0, BUSY_O}, 32'd0);
    RSTN_I = 1'b1;
    idle(20);

    // Plain frame 0x55
    expect_evt(1'b0, 8'h55);
    send_byte(8'h55, Bit, 1'b1);
    check("x55_busy_after", {31'd0, BUSY_O}, 32'd0);
    check("x55_byte", {24'd0, BYTE_O}, 32'h55);
    idle(Bit);

    // Short low glitch: START is entered, then abandoned at the midpoint
    SERIAL_I = 1'b0;
    idle(20);
    SERIAL_I = 1'b1;
    idle(Half - 20 + 1);
    check("glitch_busy_mid", {31'd0, BUSY_O}, 32'd1);
    idle(3);
    check("glitch_busy_end", {31'd0, BUSY_O}, 32'd0);
    idle(Bit);
    check("glitch_byte_kept", {24'd0, BYTE_O}, 32'h55);

    // 0xA3 with low stop bit, then 0x3C
    expect_evt(1'b1, 8'h55);
    send_byte(8'hA3, Bit, 1'b0);
    idle(Bit);
    check("ferr_byte_kept", {24'd0, BYTE_O}, 32'h55);
    check("ferr_busy_after", {31'd0, BUSY_O}, 32'd0);
    expect_evt(1'b0, 8'h3C);
    send_byte(8'h3C, Bit, 1'b1);
    check("x3c_byte", {24'd0, BYTE_O}, 32'h3C);
    idle(Bit);

    // Line held low for 20 bit times, then 0x81
    expect_evt(1'b1, 8'h3C);
    SERIAL_I = 1'b0;
    idle(20 * Bit);
    check("break_busy", {31'd0, BUSY_O}, 32'd1);
    SERIAL_I = 1'b1;
    idle(2 * Bit);
    expect_evt(1'b0, 8'h81);
    send_byte(8'h81, Bit, 1'b1);
    check("x81_byte", {24'd0, BYTE_O}, 32'h81);
    idle(Bit);

    // Back-to-back frames at -2% (102 clk/bit) and +2% (98 clk/bit)
    expect_evt(1'b0, 8'h00);
    expect_evt(1'b0, 8'hFF);
    send_byte(8'h00, 102, 1'b1);
    send_byte(8'hFF, 102, 1'b1);
    idle(Bit);
    expect_evt(1'b0, 8'h00);
    expect_evt(1'b0, 8'hFF);
    send_byte(8'h00, 98, 1'b1);
    send_byte(8'hFF, 98, 1'b1);
    idle(Bit);
    check("b2b_byte", {24'd0, BYTE_O}, 32'hFF);

    // Reset during DATA bit 4 of 0x5A; held until the aborted frame is over
    fork
      send_byte(8'h5A, Bit, 1'b1);
      begin
        idle(5 * Bit + Half);
        RSTN_I = 1'b0;
      end
    join
    idle(2);
    check("midrst_byte", {24'd0, BYTE_O}, 32'h00);
    check("midrst_busy", {31'd0, BUSY_O}, 32'd0);
    check("midrst_rdy", {31'd0, RDY_O}, 32'd0);
    check("midrst_ferr", {31'd0, FRAME_ERR_O}, 32'd0);
    RSTN_I = 1'b1;
    idle(Bit);
    expect_evt(1'b0, 8'h5A);
    send_byte(8'h5A, Bit, 1'b1);
    idle(Bit);
    check("x5a_byte", {24'd0, BYTE_O}, 32'h5A);

    check("all_events_seen", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_receive.md
SERIAL_RECEIVE -- requirements
Module: serial_receive

Interface
REQ-001 The block SHALL have parameter BIT_CLKS, default 10416, giving CLK_100_I cycles per bit (100 MHz / 9600 baud).
REQ-002 The block SHALL have parameter HALF_CLKS, default 5208, giving CLK_100_I cycles from the start-bit falling edge to the start-bit midpoint.
REQ-003 The block SHALL have port CLK_100_I, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RSTN_I, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port SERIAL_I, input, 1 bit: asynchronous UART line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port BYTE_O, output, 8 bits: the last correctly framed received byte.
REQ-007 The block SHALL have port RDY_O, output, 1 bit: one-cycle pulse when BYTE_O is updated; directly compatible with the transmitter's byte-ready input for loopback.
REQ-008 The block SHALL have port FRAME_ERR_O, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-009 The block SHALL have port BUSY_O, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 SERIAL_I SHALL pass through a 2-flop synchronizer; all decisions use the second flop (rx), giving 2 cycles of input latency.
REQ-011 The state machine SHALL have states IDLE, START, DATA, STOP and BREAK; a single cycle counter (cnt, 14 bits) and a bit index (idx, 3 bits) SHALL time it.
REQ-012 In IDLE, rx = 0 SHALL move the block to START with cnt = 0.
REQ-013 START: cnt increments each cycle; at cnt = HALF_CLKS-1, rx = 0 SHALL go to DATA with cnt = 0 and idx = 0, while rx = 1 (false start/glitch) SHALL return to IDLE with no output pulse.
REQ-014 DATA: cnt increments; at cnt = BIT_CLKS-1, rx SHALL be shifted in LSB-first and cnt reset to 0; after the sample at idx = 7 the state SHALL go to STOP, otherwise idx increments.
REQ-015 STOP: at cnt = BIT_CLKS-1, rx = 1 SHALL load BYTE_O with the shifted byte, assert RDY_O on the next cycle for exactly one cycle, and go to IDLE.
REQ-016 STOP: at cnt = BIT_CLKS-1, rx = 0 SHALL leave BYTE_O unchanged, assert FRAME_ERR_O for exactly one cycle, and go to BREAK.
REQ-017 BREAK SHALL hold until rx = 1, then go to IDLE; a line held low for any length SHALL produce exactly one FRAME_ERR_O.
REQ-018 Sampling points SHALL fall at bit midpoints; the next start bit SHALL be accepted in the cycle after the return to IDLE, so back-to-back frames with a single stop bit are received without loss.
REQ-019 The block SHALL tolerate ±2% baud mismatch with the transmitter.
REQ-020 RDY_O and FRAME_ERR_O SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-021 BYTE_O SHALL hold its value until the next valid frame; there is no consumer handshake and no overrun flag.

Reset
REQ-022 With RSTN_I = 0 at a rising edge, the block SHALL set state = IDLE, cnt = 0, idx = 0, shift register = 0x00, both synchronizer flops = 1, BYTE_O = 0x00, and RDY_O = FRAME_ERR_O = BUSY_O = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no RDY_O or FRAME_ERR_O pulse.
REQ-024 After reset release onto a line that is already low, the block SHALL treat the low as a start edge and resolve it via REQ-013 or REQ-016/017.

Verification
REQ-025 Scenario: frame 0x55 at 10416 clk/bit -> one RDY_O pulse; BYTE_O = 0x55; BUSY_O low again after the stop-bit midpoint.
REQ-026 Scenario: 100-cycle low glitch on an idle line -> back in IDLE at HALF_CLKS+2 cycles; no RDY_O or FRAME_ERR_O pulse; BYTE_O unchanged.
REQ-027 Scenario: frame 0xA3 with a low stop bit, line then high -> one FRAME_ERR_O pulse; BYTE_O keeps its previous value; the next 0x3C frame is received correctly.
REQ-028 Scenario: line held low for 20 bit times, then frame 0x81 -> exactly one FRAME_ERR_O, then RDY_O with BYTE_O = 0x81.
REQ-029 Scenario: back-to-back 0x00 then 0xFF, one stop bit each, at 9408 and 9792 baud -> two RDY_O pulses with the correct bytes in order.
REQ-030 Scenario: RSTN_I pulsed low during DATA bit 4 of a 0x5A frame -> all outputs at reset values; no pulse for the aborted frame; the following 0x5A frame is received correctly.
